demux_rr_scheduler: RTL
=======================

// Module: demux_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares a 2-to-4 demultiplexer among four destination requesters.
//  It drives the demux select pair (a, b) and enable, and issues a one-hot grant.
//  Each owner keeps the path for a bounded burst; a guard gap follows every burst.
//  It sits directly in front of the demultiplexer and is its only source of a, b and enable.
// PARAMETERS
//  BURST_LEN   4  max beats per grant before forced release; legal range 1..255
//  GAP_CYCLES  1  idle cycles (enable=0) after every burst; legal range 1..15
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  req        in   4  req[i]=1: destination i wants the demux path; level, held while wanted
//  a          out  1  demux select bit 0 (LSB of owner index)
//  b          out  1  demux select bit 1 (MSB of owner index)
//  enable     out  1  demux enable; high only in GRANT
//  grant      out  4  one-hot owner, = (1 << {b,a}) when enable=1, else 4'b0000
//  busy       out  1  high in GRANT or GAP
//  beat_cnt   out  8  beats completed in the current burst; 0 outside GRANT
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  All outputs are registered.
//  Reset: state=IDLE, a=0, b=0, enable=0, grant=0, busy=0, beat_cnt=0, last_owner=3.
//   With last_owner=3, requester 0 has top priority after reset.
//   Reset asserted mid-burst or mid-gap takes effect at the next edge; no partial beats survive.
//  FSM states: IDLE, GRANT, GAP.
//  IDLE:
//   - If req==0, stay in IDLE and hold a/b.
//   - Else pick the first i with req[i]=1, searching last_owner+1, +2, +3, +4 (mod 4).
//   - At the next edge: {b,a}=i, last_owner=i, enable=1, grant[i]=1, beat_cnt=0, state=GRANT.
//   - Latency: req rising at edge N-1 (sampled at edge N) -> enable high after edge N.
//  GRANT, at each edge with state=GRANT:
//   - req[owner]=1: beat_cnt+1. If beat_cnt+1==BURST_LEN, go to GAP; else stay.
//   - req[owner]=0: go to GAP; beat_cnt is not incremented.
//   - Requests from non-owners are ignored while in GRANT; no preemption.
//  Entering GAP: enable=0, grant=0, beat_cnt=0, busy=1; a/b hold the last owner (no glitch on select).
//  GAP: counts GAP_CYCLES cycles, then goes to IDLE with busy=0.
//   - IDLE arbitrates in its first cycle, so a pending req is granted GAP_CYCLES+1 cycles after burst end.
//  Fairness: the just-released owner has lowest priority at the next arbitration.
//   - If it is the only requester, it is re-granted after the gap.
//  Invariants: enable==|grant; grant is never multi-hot; a/b change only on the edge entering GRANT.
//  beat_cnt is 8 bits and never exceeds BURST_LEN-1 as a visible value (wraps to 0 on exit).
// TESTING
//  1. reset=1 for 2 cycles with req=4'b1111 -> all outputs 0, busy=0; after release, first grant=4'b0001, {b,a}=0.
//  2. req=4'b1111 held, BURST_LEN=4, GAP_CYCLES=1 -> grants 0001,0010,0100,1000,0001.
//     Each grant enable-high 4 cycles, separated by 1 gap cycle plus 1 arbitration cycle.
//  3. req=4'b0100 held for 2 cycles of GRANT, then dropped -> beat_cnt 0,1,2; enable falls next edge; GAP; IDLE; grant=0.
//  4. Only req[2] held continuously -> owner 2 re-granted after every gap; a=0, b=1 throughout.
//  5. req=4'b1010 with last_owner=1 -> owner 3 granted first, then owner 1 (round-robin wrap 3->0->1).
//  6. reset pulsed at beat 2 of a burst for owner 1 -> next cycle enable=0, grant=0, state IDLE.
//     With req=4'b0011, owner 0 is granted next (pointer reset).

Source files
------------

// File: rtl/demux_rr_scheduler.sv
// rtl/demux_rr_scheduler.sv - round-robin owner scheduler driving a 2-to-4 demux
//
// Shares one 2-to-4 demultiplexer among four requesters. An owner keeps the
// path for at most BURST_LEN beats, then a GAP_CYCLES guard gap follows
// before the next arbitration. The owner that just finished gets the lowest
// priority at the next arbitration.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   reset     in   synchronous, active-high
//   req[3:0]  in   level requests, one per destination
//   a         out  demux select bit 0 (owner index LSB)
//   b         out  demux select bit 1 (owner index MSB)
//   enable    out  demux enable, high only while a burst is granted
//   grant     out  one-hot owner while enable=1, otherwise 0
//   busy      out  high during a burst or its guard gap
//   beat_cnt  out  beats completed in the current burst, 0 outside a burst
module demux_rr_scheduler #(
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic       a,
  output logic       b,
  output logic       enable,
  output logic [3:0] grant,
  output logic       busy,
  output logic [7:0] beat_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state;
  logic [1:0] last_owner;
  logic [3:0] gap_cnt;

  logic [1:0] pick_idx;
  logic       pick_found;
  logic [1:0] cand;

  // Search starts just after the previous owner, so the previous owner is
  // visited last (2-bit wrap gives the mod-4 rotation for free).
  always_comb begin
    pick_idx   = last_owner;
    pick_found = 1'b0;
    cand       = last_owner;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner + 2'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      a          <= 1'b0;
      b          <= 1'b0;
      enable     <= 1'b0;
      grant      <= 4'b0000;
      busy       <= 1'b0;
      beat_cnt   <= 8'd0;
      last_owner <= 2'd3;
      gap_cnt    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // Select lines hold the previous owner until a new grant.
          if (pick_found) begin
            {b, a}     <= pick_idx;
            last_owner <= pick_idx;
            enable     <= 1'b1;
            grant      <= 4'b0001 << pick_idx;
            busy       <= 1'b1;
            beat_cnt   <= 8'd0;
            state      <= GRANT;
          end
        end

        GRANT: begin
          // Only the owner's request matters here; others wait for IDLE.
          if (req[{b, a}] && (beat_cnt + 8'd1 != 8'(BURST_LEN))) begin
            beat_cnt <= beat_cnt + 8'd1;
          end else begin
            // Burst exhausted or owner released: a/b deliberately untouched.
            enable   <= 1'b0;
            grant    <= 4'b0000;
            beat_cnt <= 8'd0;
            gap_cnt  <= 4'd0;
            state    <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt + 4'd1 == 4'(GAP_CYCLES)) begin
            gap_cnt <= 4'd0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
